// File: rtl/switch_ingress_arbiter.sv
// switch_ingress_arbiter
//   Shares the switch's single ingress port among NREQ requesters. Bursts are
//   granted round-robin and capped at MAX_BURST beats per grant. All
//   switch-side outputs are registered.
// Ports:
//   clk       rising-edge clock
//   rstn      synchronous reset, active high (1 = reset)
//   req       per-requester beat request
//   req_addr  packed per-requester address, requester i at [i*ADDR_W +: ADDR_W]
//   req_data  packed per-requester data,    requester i at [i*DATA_W +: DATA_W]
//   sw_rdy    switch can take a beat this cycle
//   ack       one-hot, combinational: requester's beat consumed this cycle
//   vld/addr/data  registered beat to the switch, one cycle after its ack
//   owner     current/last grant holder
//   busy      arbiter is inside a burst
module switch_ingress_arbiter #(
  parameter int NREQ      = 4,
  parameter int ADDR_W    = 2,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4,
  localparam int PTR_W    = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int CNT_W    = $clog2(MAX_BURST + 1)
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  input  logic                     sw_rdy,
  output logic [NREQ-1:0]          ack,
  output logic                     vld,
  output logic [ADDR_W-1:0]        addr,
  output logic [DATA_W-1:0]        data,
  output logic [PTR_W-1:0]         owner,
  output logic                     busy
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t            state_q, state_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PTR_W-1:0]  owner_d;
  logic              busy_d;
  logic              accept;
  logic [PTR_W-1:0]  sel;

  // round-robin search results
  logic              found;
  logic [PTR_W-1:0]  gnt;
  logic [PTR_W:0]    idx;

  // per-requester views of the packed buses
  logic [ADDR_W-1:0] addr_a [NREQ];
  logic [DATA_W-1:0] data_a [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign addr_a[i] = req_addr[i*ADDR_W +: ADDR_W];
    assign data_a[i] = req_data[i*DATA_W +: DATA_W];
  end

  function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(NREQ - 1)) ? '0 : p + 1'b1;
  endfunction

  // First set request at or after ptr, wrapping. idx is one bit wider than
  // the pointer so ptr+k never overflows before the wrap subtraction.
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, ptr_q} + (PTR_W+1)'(k);
      if (idx >= (PTR_W+1)'(NREQ)) idx = idx - (PTR_W+1)'(NREQ);
      if (!found && req[idx[PTR_W-1:0]]) begin
        found = 1'b1;
        gnt   = idx[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    owner_d = owner;
    busy_d  = busy;
    accept  = 1'b0;
    sel     = owner;
    case (state_q)
      IDLE: begin
        if (sw_rdy && found) begin
          accept  = 1'b1;
          sel     = gnt;
          owner_d = gnt;
          if (MAX_BURST == 1) begin
            // single-beat grants never enter BURST
            ptr_d = nxt(gnt);
          end else begin
            cnt_d   = CNT_W'(1);
            busy_d  = 1'b1;
            state_d = BURST;
          end
        end
      end
      BURST: begin
        // release wins over stall: a capped owner gives up even if sw_rdy=0
        if (!req[owner] || cnt_q >= CNT_W'(MAX_BURST)) begin
          ptr_d   = nxt(owner);
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (sw_rdy) begin
          accept = 1'b1;
          cnt_d  = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // nothing is consumed in a reset cycle
    if (rstn) accept = 1'b0;
  end

  always_comb begin
    ack = '0;
    if (accept) ack[sel] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      owner   <= '0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      owner   <= owner_d;
      busy    <= busy_d;
    end
  end

  // switch port: addr/data hold their last beat while vld is low
  always_ff @(posedge clk) begin
    if (rstn) begin
      vld  <= 1'b0;
      addr <= '0;
      data <= '0;
    end else begin
      vld <= accept;
      if (accept) begin
        addr <= addr_a[sel];
        data <= data_a[sel];
      end
    end
  end

endmodule

// File: tb/tb_switch_ingress_arbiter.sv
module tb_switch_ingress_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int rown   = 0;

  localparam logic [31:0] D0 = 32'h3322_1100;
  localparam logic [7:0]  AV = 8'b11_10_01_00;

  // DUT A: MAX_BURST=4
  logic       rst_a, rdy_a, vld_a, busy_a;
  logic [3:0] req_a, ack_a;
  logic [31:0] rd_a;
  logic [1:0] addr_a, own_a;
  logic [7:0] data_a;

  // DUT B: MAX_BURST=2
  logic       rst_b, vld_b, busy_b;
  logic [3:0] req_b, ack_b;
  logic [1:0] addr_b, own_b;
  logic [7:0] data_b;

  switch_ingress_arbiter #(.NREQ(4), .ADDR_W(2), .DATA_W(8), .MAX_BURST(4)) u_a (
    .clk(clk), .rstn(rst_a), .req(req_a), .req_addr(AV), .req_data(rd_a),
    .sw_rdy(rdy_a), .ack(ack_a), .vld(vld_a), .addr(addr_a), .data(data_a),
    .owner(own_a), .busy(busy_a));

  switch_ingress_arbiter #(.NREQ(4), .ADDR_W(2), .DATA_W(8), .MAX_BURST(2)) u_b (
    .clk(clk), .rstn(rst_b), .req(req_b), .req_addr(AV), .req_data(D0),
    .sw_rdy(1'b1), .ack(ack_b), .vld(vld_b), .addr(addr_b), .data(data_b),
    .owner(own_b), .busy(busy_b));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL row%0d %s got %0h exp %0h", rown, tag, got, exp);
    end
  endtask

  // apply inputs, check ack (this cycle) and registered outputs (last edge),
  // then advance one clock
  task automatic row(input logic rst, input logic [3:0] r, input logic rdy,
                     input logic [31:0] rd, input logic [3:0] eack, input logic evld,
                     input logic [1:0] eaddr, input logic [7:0] edata,
                     input logic [1:0] eown, input logic ebusy);
    rown++;
    rst_a = rst; req_a = r; rdy_a = rdy; rd_a = rd;
    #1;
    chk("a_ack",   32'(ack_a),  32'(eack));
    chk("a_vld",   32'(vld_a),  32'(evld));
    chk("a_addr",  32'(addr_a), 32'(eaddr));
    chk("a_data",  32'(data_a), 32'(edata));
    chk("a_owner", 32'(own_a),  32'(eown));
    chk("a_busy",  32'(busy_a), 32'(ebusy));
    @(posedge clk); #1;
  endtask

  task automatic rowb(input logic [3:0] r, input logic [3:0] eack, input logic evld,
                      input logic [1:0] eaddr, input logic [1:0] eown, input logic ebusy);
    rown++;
    rst_b = 1'b0; req_b = r;
    #1;
    chk("b_ack",   32'(ack_b),  32'(eack));
    chk("b_vld",   32'(vld_b),  32'(evld));
    chk("b_addr",  32'(addr_b), 32'(eaddr));
    chk("b_owner", 32'(own_b),  32'(eown));
    chk("b_busy",  32'(busy_b), 32'(ebusy));
    @(posedge clk); #1;
  endtask

  initial begin
    rst_a = 1'b1; req_a = 4'hf; rdy_a = 1'b1; rd_a = D0;
    rst_b = 1'b1; req_b = 4'h0;
    @(posedge clk); #1;

    // reset held with all requests up
    row(1, 4'hf, 1, D0, 4'h0, 0, 0, 8'h00, 0, 0);
    row(1, 4'hf, 1, D0, 4'h0, 0, 0, 8'h00, 0, 0);
    // first grant to req0, 4-beat cap, release gap, then req1
    row(0, 4'hf, 1, D0, 4'h1, 0, 0, 8'h00, 0, 0);
    row(0, 4'hf, 1, D0, 4'h1, 1, 0, 8'h00, 0, 1);
    row(0, 4'hf, 1, D0, 4'h1, 1, 0, 8'h00, 0, 1);
    row(0, 4'hf, 1, D0, 4'h1, 1, 0, 8'h00, 0, 1);
    row(0, 4'hf, 1, D0, 4'h0, 1, 0, 8'h00, 0, 1);
    row(0, 4'hf, 1, D0, 4'h2, 0, 0, 8'h00, 0, 0);
    // backpressure: owner 1 at cnt=2 stalls 3 cycles, then 2 more beats
    row(0, 4'hf, 1, D0, 4'h2, 1, 1, 8'h11, 1, 1);
    row(0, 4'hf, 0, D0, 4'h0, 1, 1, 8'h11, 1, 1);
    row(0, 4'hf, 0, D0, 4'h0, 0, 1, 8'h11, 1, 1);
    row(0, 4'hf, 0, D0, 4'h0, 0, 1, 8'h11, 1, 1);
    row(0, 4'hf, 1, D0, 4'h2, 0, 1, 8'h11, 1, 1);
    row(0, 4'hf, 1, D0, 4'h2, 1, 1, 8'h11, 1, 1);
    row(0, 4'hf, 1, D0, 4'h0, 1, 1, 8'h11, 1, 1);
    // single requester 2, incrementing data, 4 beats / gap / 4 beats
    row(0, 4'h4, 1, 32'h3310_1100, 4'h4, 0, 1, 8'h11, 1, 0);
    row(0, 4'h4, 1, 32'h3311_1100, 4'h4, 1, 2, 8'h10, 2, 1);
    row(0, 4'h4, 1, 32'h3312_1100, 4'h4, 1, 2, 8'h11, 2, 1);
    row(0, 4'h4, 1, 32'h3313_1100, 4'h4, 1, 2, 8'h12, 2, 1);
    row(0, 4'h4, 1, 32'h3314_1100, 4'h0, 1, 2, 8'h13, 2, 1);
    row(0, 4'h4, 1, 32'h3314_1100, 4'h4, 0, 2, 8'h13, 2, 0);
    row(0, 4'h4, 1, 32'h3315_1100, 4'h4, 1, 2, 8'h14, 2, 1);
    row(0, 4'h4, 1, 32'h3316_1100, 4'h4, 1, 2, 8'h15, 2, 1);
    row(0, 4'h4, 1, 32'h3317_1100, 4'h4, 1, 2, 8'h16, 2, 1);
    row(0, 4'h4, 1, 32'h3317_1100, 4'h0, 1, 2, 8'h17, 2, 1);
    // owner 3 reset at cnt=2, then regranted with a full fresh burst
    row(0, 4'h8, 1, D0, 4'h8, 0, 2, 8'h17, 2, 0);
    row(0, 4'h8, 1, D0, 4'h8, 1, 3, 8'h33, 3, 1);
    row(1, 4'h8, 1, D0, 4'h0, 1, 3, 8'h33, 3, 1);
    row(0, 4'h8, 1, D0, 4'h8, 0, 0, 8'h00, 0, 0);
    row(0, 4'h8, 1, D0, 4'h8, 1, 3, 8'h33, 3, 1);
    row(0, 4'h8, 1, D0, 4'h8, 1, 3, 8'h33, 3, 1);
    row(0, 4'h8, 1, D0, 4'h8, 1, 3, 8'h33, 3, 1);
    row(0, 4'h8, 1, D0, 4'h0, 1, 3, 8'h33, 3, 1);
    // round-robin over 1011, each owner drops after one beat: 0,1,3,0
    row(0, 4'hb, 1, D0, 4'h1, 0, 3, 8'h33, 3, 0);
    row(0, 4'ha, 1, D0, 4'h0, 1, 0, 8'h00, 0, 1);
    row(0, 4'hb, 1, D0, 4'h2, 0, 0, 8'h00, 0, 0);
    row(0, 4'h9, 1, D0, 4'h0, 1, 1, 8'h11, 1, 1);
    row(0, 4'hb, 1, D0, 4'h8, 0, 1, 8'h11, 1, 0);
    row(0, 4'h3, 1, D0, 4'h0, 1, 3, 8'h33, 3, 1);
    row(0, 4'hb, 1, D0, 4'h1, 0, 3, 8'h33, 3, 0);
    row(0, 4'h0, 1, D0, 4'h0, 1, 0, 8'h00, 0, 1);
    row(0, 4'h0, 1, D0, 4'h0, 0, 0, 8'h00, 0, 0);

    // burst cap of 2 with 0011 held: 0,0,gap,1,1,gap,0,0,gap
    rowb(4'h3, 4'h1, 0, 0, 0, 0);
    rowb(4'h3, 4'h1, 1, 0, 0, 1);
    rowb(4'h3, 4'h0, 1, 0, 0, 1);
    rowb(4'h3, 4'h2, 0, 0, 0, 0);
    rowb(4'h3, 4'h2, 1, 1, 1, 1);
    rowb(4'h3, 4'h0, 1, 1, 1, 1);
    rowb(4'h3, 4'h1, 0, 1, 1, 0);
    rowb(4'h3, 4'h1, 1, 0, 0, 1);
    rowb(4'h3, 4'h0, 1, 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
